// File: rtl/pc_valid_pipe.sv
// -----------------------------------------------------------------------------
// pc_valid_pipe
//
// This pipeline runs beside the datapath pipe. It carries a valid flag and a
// PC_W-bit PC through DEPTH stages. out_v and out_pc qualify the writeback
// stage.
//
// Behaviour summary:
//   - A branch (br) squashes the valids leaving stages 1..BR_KILL.
//   - A branch-commit (br_c) squashes the valids leaving stages 1..BRC_KILL.
//   - A stall holds stages 1..STALL_STAGE and inserts a bubble into stage
//     STALL_STAGE+1. The tail of the pipe keeps draining.
//   - en=0 freezes every stage. Any squash issued while en=0 is dropped.
//   - occ is the number of stages that currently hold a valid entry.
//
// Parameters:
//   DEPTH       number of stages (2..32)
//   PC_W        PC width in bits
//   BR_KILL     last stage squashed by br (0 disables br)
//   BRC_KILL    last stage squashed by br_c (BR_KILL <= BRC_KILL < DEPTH)
//   STALL_STAGE last stage held by stall (1..DEPTH-1)
//   CNT_W       occupancy width; derived from DEPTH, do not override
//
// Ports:
//   clk     in   clock; all state updates on the rising edge
//   r       in   synchronous active-high reset; overrides every other input
//   en      in   global advance enable
//   stall   in   hold the front stages and bubble the stage behind them
//   in_v    in   valid of the instruction entering stage 1
//   in_pc   in   PC entering stage 1
//   br      in   branch squash
//   br_c    in   branch-commit squash
//   out_v   out  valid of stage DEPTH
//   out_pc  out  PC of stage DEPTH
//   occ     out  popcount of all stage valids (combinational)
//   in_rdy  out  en & ~stall (combinational); high when stage 1 accepts input
// -----------------------------------------------------------------------------
module pc_valid_pipe #(
    parameter int DEPTH       = 6,
    parameter int PC_W        = 32,
    parameter int BR_KILL     = 3,
    parameter int BRC_KILL    = 5,
    parameter int STALL_STAGE = 2,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             r,
    input  logic             en,
    input  logic             stall,
    input  logic             in_v,
    input  logic [PC_W-1:0]  in_pc,
    input  logic             br,
    input  logic             br_c,
    output logic             out_v,
    output logic [PC_W-1:0]  out_pc,
    output logic [CNT_W-1:0] occ,
    output logic             in_rdy
);

    // Stage state. Index 1 is the entry stage and index DEPTH is writeback.
    logic [DEPTH:1]  v_q;
    logic [DEPTH:1]  v_d;
    logic [PC_W-1:0] pc_q [1:DEPTH];
    logic [PC_W-1:0] pc_d [1:DEPTH];

    // kill[k] squashes the valid that leaves stage k this cycle. Stage DEPTH
    // has no successor, so it never needs a kill term.
    logic [DEPTH-1:1] kill;

    genvar gi;

    // ------------------------------------------------------------------
    // Per-stage kill terms. The window membership is fixed when the
    // design is elaborated, so each term reduces to a gated br or br_c.
    // ------------------------------------------------------------------
    generate
        for (gi = 1; gi <= DEPTH - 1; gi++) begin : g_kill
            localparam bit IN_BR  = (gi <= BR_KILL);
            localparam bit IN_BRC = (gi <= BRC_KILL);
            assign kill[gi] = (br & IN_BR) | (br_c & IN_BRC);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state per stage. Stages fall into four classes:
    //   first  : stage 1; loads input on advance, held under stall
    //   held   : stages 2..STALL_STAGE; held under stall
    //   bubble : stage STALL_STAGE+1; loads v=0/pc=0 under stall
    //   tail   : everything behind the bubble; always advances when en=1
    // A held stage still self-squashes. Under stall its own valid is
    // masked by its own kill term, so a branch during a stall is not lost.
    // ------------------------------------------------------------------
    generate
        for (gi = 1; gi <= DEPTH; gi++) begin : g_stage
            if (gi == 1) begin : g_first
                assign v_d[gi]  = !en   ? v_q[gi]
                                : stall ? (v_q[gi] & ~kill[gi])
                                :         in_v;
                assign pc_d[gi] = (en && !stall) ? in_pc : pc_q[gi];
            end else if (gi <= STALL_STAGE) begin : g_held
                assign v_d[gi]  = !en   ? v_q[gi]
                                : stall ? (v_q[gi] & ~kill[gi])
                                :         (v_q[gi-1] & ~kill[gi-1]);
                assign pc_d[gi] = (en && !stall) ? pc_q[gi-1] : pc_q[gi];
            end else if (gi == STALL_STAGE + 1) begin : g_bubble
                assign v_d[gi]  = !en   ? v_q[gi]
                                : stall ? 1'b0
                                :         (v_q[gi-1] & ~kill[gi-1]);
                assign pc_d[gi] = !en   ? pc_q[gi]
                                : stall ? '0
                                :         pc_q[gi-1];
            end else begin : g_tail
                assign v_d[gi]  = en ? (v_q[gi-1] & ~kill[gi-1]) : v_q[gi];
                assign pc_d[gi] = en ? pc_q[gi-1] : pc_q[gi];
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State registers. Every bit is cleared so nothing undefined can reach
    // writeback, even when r is asserted in the middle of operation.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (r) begin
            v_q <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                pc_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            for (int k = 1; k <= DEPTH; k++) begin
                pc_q[k] <= pc_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_v  = v_q[DEPTH];
    assign out_pc = pc_q[DEPTH];
    assign in_rdy = en & ~stall;

    // CNT_W holds the value DEPTH, so the count cannot wrap.
    always_comb begin
        occ = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            occ = occ + CNT_W'(v_q[k]);
        end
    end

endmodule

// File: tb/tb_pc_valid_pipe.sv
// -----------------------------------------------------------------------------
// tb_pc_valid_pipe
//
// Directed scoreboard bench for pc_valid_pipe (DEPTH=6, PC_W=8, BR_KILL=3,
// BRC_KILL=5, STALL_STAGE=2). The driver applies one vector per cycle on the
// falling edge and queues the outputs it expects after the next rising edge.
// The monitor, 1 time unit after each rising edge, pops that entry and
// compares it.
// -----------------------------------------------------------------------------
module tb_pc_valid_pipe;

    localparam int DEPTH = 6;
    localparam int PC_W  = 8;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             r = 1'b1;
    logic             en = 1'b0;
    logic             stall = 1'b0;
    logic             in_v = 1'b0;
    logic [PC_W-1:0]  in_pc = '0;
    logic             br = 1'b0;
    logic             br_c = 1'b0;
    logic             out_v;
    logic [PC_W-1:0]  out_pc;
    logic [CNT_W-1:0] occ;
    logic             in_rdy;

    always #5 clk = ~clk;

    pc_valid_pipe #(
        .DEPTH       (DEPTH),
        .PC_W        (PC_W),
        .BR_KILL     (3),
        .BRC_KILL    (5),
        .STALL_STAGE (2)
    ) dut (
        .clk    (clk),
        .r      (r),
        .en     (en),
        .stall  (stall),
        .in_v   (in_v),
        .in_pc  (in_pc),
        .br     (br),
        .br_c   (br_c),
        .out_v  (out_v),
        .out_pc (out_pc),
        .occ    (occ),
        .in_rdy (in_rdy)
    );

    typedef struct {
        logic             ov;
        logic [PC_W-1:0]  opc;
        logic [CNT_W-1:0] oc;
        logic             rdy;
        int               tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor. A single pending entry applies to the edge just passed.
    // in_rdy still reflects the inputs that were used at that edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (out_v !== e.ov) begin
                    n_fail++;
                    $display("FAIL out_v tag=%0d got=%0b want=%0b", e.tag, out_v, e.ov);
                end
                n_checks++;
                if (out_pc !== e.opc) begin
                    n_fail++;
                    $display("FAIL out_pc tag=%0d got=%02h want=%02h", e.tag, out_pc, e.opc);
                end
                n_checks++;
                if (occ !== e.oc) begin
                    n_fail++;
                    $display("FAIL occ tag=%0d got=%0d want=%0d", e.tag, occ, e.oc);
                end
                n_checks++;
                if (in_rdy !== e.rdy) begin
                    n_fail++;
                    $display("FAIL in_rdy tag=%0d got=%0b want=%0b", e.tag, in_rdy, e.rdy);
                end
                $display("txn tag=%0d out_v=%0b out_pc=%02h occ=%0d in_rdy=%0b",
                         e.tag, out_v, out_pc, occ, in_rdy);
            end
        end
    end

    // Apply one input vector and queue the outputs expected after the edge.
    task automatic cyc(input logic r_i, input logic en_i, input logic st_i,
                       input logic iv_i, input logic [PC_W-1:0] ipc_i,
                       input logic br_i, input logic brc_i,
                       input logic e_ov, input logic [PC_W-1:0] e_opc,
                       input logic [CNT_W-1:0] e_occ, input logic e_rdy,
                       input int tag);
        exp_t e;
        @(negedge clk);
        r     = r_i;
        en    = en_i;
        stall = st_i;
        in_v  = iv_i;
        in_pc = ipc_i;
        br    = br_i;
        br_c  = brc_i;
        e.ov  = e_ov;
        e.opc = e_opc;
        e.oc  = e_occ;
        e.rdy = e_rdy;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Reset, then push 0x10..0x15. Afterwards pc[1..6]=0x15..0x10, all valid.
    task automatic fill(input int base);
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, base);
        for (int k = 0; k < DEPTH; k++) begin
            cyc(0, 1, 0, 1, 8'h10 + 8'(k), 0, 0,
                (k == DEPTH - 1), (k == DEPTH - 1) ? 8'h10 : 8'h00,
                CNT_W'(k + 1), 1, base + 1 + k);
        end
    endtask

    initial begin
        // 1: basic fill and latency, then one drain step
        fill(100);
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h11, 5, 1, 107);

        // 2: branch squashes the valids leaving stages 1..3
        fill(200);
        cyc(0, 1, 0, 1, 8'h16, 1, 0, 1, 8'h11, 3, 1, 207);
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h12, 2, 1, 208);
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 0, 8'h13, 1, 1, 209);

        // 3: branch-commit squashes the valids leaving stages 1..5
        fill(300);
        cyc(0, 1, 0, 1, 8'h16, 0, 1, 0, 8'h11, 1, 1, 307);

        // 4: two-cycle stall, release, then track the held 0x14 to writeback
        fill(400);
        cyc(0, 1, 1, 1, 8'h99, 0, 0, 1, 8'h11, 5, 0, 407);
        cyc(0, 1, 1, 1, 8'h99, 0, 0, 1, 8'h12, 4, 0, 408);
        cyc(0, 1, 0, 0, 8'h20, 0, 0, 1, 8'h13, 3, 1, 409);
        cyc(0, 1, 0, 0, 8'h21, 0, 0, 0, 8'h00, 2, 1, 410);
        cyc(0, 1, 0, 0, 8'h22, 0, 0, 0, 8'h00, 2, 1, 411);
        cyc(0, 1, 0, 0, 8'h23, 0, 0, 1, 8'h14, 2, 1, 412);

        // 4b: stall with br. Held stages self-squash and the tail is killed at 3.
        fill(450);
        cyc(0, 1, 1, 1, 8'h99, 1, 0, 1, 8'h11, 2, 0, 457);

        // 4c: stall with br_c. The wider window empties the whole pipe.
        fill(470);
        cyc(0, 1, 1, 1, 8'h99, 0, 1, 0, 8'h11, 0, 0, 477);

        // 5: en=0 freezes the pipe and the squash is lost
        fill(500);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 1, 8'h77, 1, 1, 1, 8'h10, 6, 0, 507 + k);
        end
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 8'h11, 5, 1, 510);

        // 6: reset overrides en=0/stall/br, then the pipe restarts cleanly
        fill(600);
        cyc(1, 0, 1, 1, 8'h55, 1, 0, 0, 8'h00, 0, 0, 607);
        cyc(0, 1, 0, 1, 8'h30, 0, 0, 0, 8'h00, 1, 1, 608);

        // Let the monitor drain the queue, with a bound on the wait.
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) begin
            @(negedge clk);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
